// File: rtl/sr_send_data_pkg.sv
// Shared definitions for the TMIIa shift-register send path.
// Holds the default word and counter widths and the one-hot FSM state
// encoding used by sr_send_data.
package sr_send_data_pkg;

  // TMIIa shift-register word width and counter width (counter is CNT+1 bits)
  localparam int TMII_DATA_WIDTH = 170;
  localparam int TMII_CNT_WIDTH  = 8;

  // One-hot state encoding
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_LOAD  = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

endpackage

// File: rtl/sr_send_data.sv
// sr_send_data: upstream serializer for the TMIIa shift-register path.
// On an accepted start the word on din is latched, driven out one bit per
// clk on data_out while sr_clk_en gates the chip shift clock, and then the
// chip load strobe sr_load is pulsed. rx_start marks the first shifted bit
// so a capture stage can read back the chip's old contents in the same pass.
//
// Ports
//   clk        in   control clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   start      in   transfer request, sampled only in IDLE
//   din        in   DATA_WIDTH word, sampled on the accepting cycle
//   data_out   out  serial bit to the chip SR input
//   sr_clk_en  out  high for exactly DATA_WIDTH shift cycles
//   sr_load    out  chip parallel-load strobe (LOAD_PULSE_WIDTH cycles)
//   rx_start   out  one-cycle pulse with the first shifted bit
//   busy       out  high from the cycle after acceptance through DONE
//   done       out  one-cycle completion pulse
//   state_dbg  out  current one-hot FSM state, for observation only
//
// Handshake: start is a level request; it is accepted only while the FSM
// sits in IDLE and is otherwise ignored, never queued. All outputs are
// registered and one cycle behind the state that produced them.
module sr_send_data
  import sr_send_data_pkg::*;
#(
  parameter int DATA_WIDTH       = TMII_DATA_WIDTH,
  parameter int CNT_WIDTH        = TMII_CNT_WIDTH,
  parameter int SHIFT_DIRECTION  = 1,
  parameter int LOAD_PULSE_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  data_out,
  output logic                  sr_clk_en,
  output logic                  sr_load,
  output logic                  rx_start,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            state_dbg
);

  localparam int CW = CNT_WIDTH + 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LOAD_LAST =
    CW'((LOAD_PULSE_WIDTH > 0) ? (LOAD_PULSE_WIDTH - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  data_out_q, data_out_d;
  logic                  sr_clk_en_q, sr_clk_en_d;
  logic                  sr_load_q, sr_load_d;
  logic                  rx_start_q, rx_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    // Every output is a per-cycle decode of the current state, so default low
    data_out_d  = 1'b0;
    sr_clk_en_d = 1'b0;
    sr_load_d   = 1'b0;
    rx_start_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          shreg_d = din;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      ST_SHIFT: begin
        busy_d      = 1'b1;
        sr_clk_en_d = 1'b1;
        rx_start_d  = (cnt_q == '0);
        if (SHIFT_DIRECTION != 0) begin
          data_out_d = shreg_q[DATA_WIDTH-1];
          shreg_d    = shreg_q << 1;
        end else begin
          data_out_d = shreg_q[0];
          shreg_d    = shreg_q >> 1;
        end
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = (LOAD_PULSE_WIDTH == 0) ? ST_DONE : ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_LOAD: begin
        busy_d    = 1'b1;
        sr_load_d = 1'b1;
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        // Corrupted one-hot encoding: park in IDLE with a clean datapath
        state_d = ST_IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_out_q  <= 1'b0;
      sr_clk_en_q <= 1'b0;
      sr_load_q   <= 1'b0;
      rx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      sr_clk_en_q <= sr_clk_en_d;
      sr_load_q   <= sr_load_d;
      rx_start_q  <= rx_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign data_out  = data_out_q;
  assign sr_clk_en = sr_clk_en_q;
  assign sr_load   = sr_load_q;
  assign rx_start  = rx_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sr_send_data.sv
// Bench for sr_send_data. Three instances share stimulus:
//   dut_a MSB-first, 2-cycle load pulse
//   dut_b LSB-first, 2-cycle load pulse
//   dut_c MSB-first, no load pulse
// mon_sel picks which instance the watcher observes.
module tb_sr_send_data;

  localparam int DW = 170;

  localparam logic [DW-1:0] W_ALT =
    170'h2_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AA;
  localparam logic [DW-1:0] W_ONE = 170'h1;
  localparam logic [DW-1:0] W_K1  =
    170'h2_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0_0BAD_F00D;
  localparam logic [DW-1:0] W_K2  =
    170'h1_0F0F_3C3C_5555_0001_8000_FFFF_0000_1357_9BDF_2468_AC;
  localparam logic [DW-1:0] W_K3  =
    170'h3_8001_4002_2004_1008_0810_0420_0240_0180_7E7E_C3C3_99;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] din = '0;

  logic a_do, a_en, a_ld, a_rx, a_busy, a_done;
  logic b_do, b_en, b_ld, b_rx, b_busy, b_done;
  logic c_do, c_en, c_ld, c_rx, c_busy, c_done;
  logic [3:0] a_st, b_st, c_st;

  sr_send_data #(.DATA_WIDTH(DW), .CNT_WIDTH(8), .SHIFT_DIRECTION(1), .LOAD_PULSE_WIDTH(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .data_out(a_do), .sr_clk_en(a_en), .sr_load(a_ld), .rx_start(a_rx),
    .busy(a_busy), .done(a_done), .state_dbg(a_st)
  );

  sr_send_data #(.DATA_WIDTH(DW), .CNT_WIDTH(8), .SHIFT_DIRECTION(0), .LOAD_PULSE_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .data_out(b_do), .sr_clk_en(b_en), .sr_load(b_ld), .rx_start(b_rx),
    .busy(b_busy), .done(b_done), .state_dbg(b_st)
  );

  sr_send_data #(.DATA_WIDTH(DW), .CNT_WIDTH(8), .SHIFT_DIRECTION(1), .LOAD_PULSE_WIDTH(0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .data_out(c_do), .sr_clk_en(c_en), .sr_load(c_ld), .rx_start(c_rx),
    .busy(c_busy), .done(c_done), .state_dbg(c_st)
  );

  int mon_sel = 0;
  logic m_do, m_en, m_ld, m_rx, m_busy, m_done;
  logic [3:0] m_st;

  always_comb begin
    case (mon_sel)
      1: begin
        m_do = b_do; m_en = b_en; m_ld = b_ld; m_rx = b_rx;
        m_busy = b_busy; m_done = b_done; m_st = b_st;
      end
      2: begin
        m_do = c_do; m_en = c_en; m_ld = c_ld; m_rx = c_rx;
        m_busy = c_busy; m_done = c_done; m_st = c_st;
      end
      default: begin
        m_do = a_do; m_en = a_en; m_ld = a_ld; m_rx = a_rx;
        m_busy = a_busy; m_done = a_done; m_st = a_st;
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] w(input int x);
    return DW'(x);
  endfunction

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
    return r;
  endfunction

  // ---------------- watcher state ----------------
  int n_en, n_rx, n_ld, n_done, n_busy, n_stray, en_runs, rx_al, load_first;
  int rx_idx[4];
  int done_idx[4];
  logic [DW-1:0] word;
  logic [DW-1:0] cap;
  logic [DW-1:0] chip = '0;   // model of the chip's own shift register
  logic [5:0] snap;
  logic [3:0] snap_st;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic launch(input logic [DW-1:0] wd);
    @(negedge clk);
    din = wd;
    start = 1'b1;
    rst = 1'b0;
  endtask

  // Iteration i samples outputs produced by the i-th posedge after launch,
  // then drives start/rst for the next posedge.
  task automatic watch(input int n, input bit hold, input int p1, input int p2, input int rstc);
    logic prev_en;
    prev_en = 1'b0;
    n_en = 0; n_rx = 0; n_ld = 0; n_done = 0; n_busy = 0; n_stray = 0;
    en_runs = 0; rx_al = 0; load_first = -1;
    for (int k = 0; k < 4; k++) begin
      rx_idx[k] = -1;
      done_idx[k] = -1;
    end
    word = '0;
    cap = '0;
    snap = '0;
    snap_st = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_en) begin
        n_en++;
        if (!prev_en) en_runs++;
        word = {word[DW-2:0], m_do};
        cap  = {cap[DW-2:0], chip[DW-1]};
        chip = {chip[DW-2:0], m_do};
      end
      if (m_do && !m_en) n_stray++;
      if (m_rx) begin
        if (n_rx < 4) rx_idx[n_rx] = i;
        n_rx++;
        if (m_en && !prev_en) rx_al++;
      end
      if (m_ld) begin
        if (n_ld == 0) load_first = i;
        n_ld++;
      end
      if (m_done) begin
        if (n_done < 4) done_idx[n_done] = i;
        n_done++;
      end
      if (m_busy) n_busy++;
      if (i == rstc + 1) begin
        snap = {m_do, m_en, m_ld, m_rx, m_busy, m_done};
        snap_st = m_st;
      end
      prev_en = m_en;
      start = hold || (i == p1) || (i == p2);
      rst = (i == rstc);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DW-1:0] e;
    logic [DW-1:0] w_rand;

    // Reset with start asserted: reset must win
    rst = 1'b1;
    start = 1'b1;
    din = '1;
    repeat (3) @(negedge clk);
    check("rst_out_a", w({a_do, a_en, a_ld, a_rx, a_busy, a_done}), w(0));
    check("rst_out_b", w({b_do, b_en, b_ld, b_rx, b_busy, b_done}), w(0));
    check("rst_out_c", w({c_do, c_en, c_ld, c_rx, c_busy, c_done}), w(0));
    check("rst_state_a", w(a_st), w(1));
    check("rst_state_c", w(c_st), w(1));
    rst = 1'b0;
    start = 1'b0;

    // 1: MSB-first alternating pattern
    mon_sel = 0;
    exp_q.push_back(W_ALT);
    launch(W_ALT);
    watch(180, 1'b0, -1, -1, -1);
    e = exp_q.pop_front();
    check("t1_word", word, e);
    check("t1_en_cycles", w(n_en), w(170));
    check("t1_en_runs", w(en_runs), w(1));
    check("t1_rx_count", w(n_rx), w(1));
    check("t1_rx_aligned", w(rx_al), w(1));
    check("t1_rx_idx", w(rx_idx[0]), w(1));
    check("t1_load_cycles", w(n_ld), w(2));
    check("t1_load_first", w(load_first), w(171));
    check("t1_done_count", w(n_done), w(1));
    check("t1_done_idx", w(done_idx[0]), w(173));
    check("t1_busy_cycles", w(n_busy), w(174));
    check("t1_stray_bits", w(n_stray), w(0));

    // 2: LSB-first, din = 1 -> single leading one
    do_reset();
    mon_sel = 1;
    exp_q.push_back(rev(W_ONE));
    launch(W_ONE);
    watch(180, 1'b0, -1, -1, -1);
    e = exp_q.pop_front();
    check("t2_word", word, e);
    check("t2_en_cycles", w(n_en), w(170));
    check("t2_done_idx", w(done_idx[0]), w(173));

    // 3: start re-pulsed mid-shift and during LOAD
    do_reset();
    mon_sel = 0;
    exp_q.push_back(W_K1);
    launch(W_K1);
    watch(200, 1'b0, 51, 171, -1);
    e = exp_q.pop_front();
    check("t3_word", word, e);
    check("t3_en_cycles", w(n_en), w(170));
    check("t3_rx_count", w(n_rx), w(1));
    check("t3_done_count", w(n_done), w(1));
    check("t3_done_idx", w(done_idx[0]), w(173));

    // 4: reset at shift cycle 80, then a fresh full word
    do_reset();
    mon_sel = 0;
    launch(W_K1);
    watch(200, 1'b0, -1, -1, 81);
    check("t4_out_after_rst", w(snap), w(0));
    check("t4_state_after_rst", w(snap_st), w(1));
    check("t4_en_cycles", w(n_en), w(81));
    check("t4_no_load", w(n_ld), w(0));
    check("t4_no_done", w(n_done), w(0));
    exp_q.push_back(W_K2);
    launch(W_K2);
    watch(180, 1'b0, -1, -1, -1);
    e = exp_q.pop_front();
    check("t4_fresh_word", word, e);
    check("t4_fresh_en", w(n_en), w(170));
    check("t4_fresh_done", w(n_done), w(1));

    // 5a: start held high, back-to-back with load pulse
    do_reset();
    mon_sel = 0;
    exp_q.push_back(W_K3);
    launch(W_K3);
    watch(348, 1'b1, -1, -1, -1);
    start = 1'b0;
    e = exp_q.pop_front();
    check("t5a_word", word, e);
    check("t5a_done_count", w(n_done), w(2));
    check("t5a_done_idx", w(done_idx[0]), w(173));
    check("t5a_rx_idx1", w(rx_idx[1]), w(175));
    check("t5a_load_cycles", w(n_ld), w(4));
    check("t5a_en_cycles", w(n_en), w(340));

    // 5b: start held high, no load pulse
    do_reset();
    mon_sel = 2;
    exp_q.push_back(W_K3);
    launch(W_K3);
    watch(344, 1'b1, -1, -1, -1);
    start = 1'b0;
    e = exp_q.pop_front();
    check("t5b_word", word, e);
    check("t5b_done_count", w(n_done), w(2));
    check("t5b_done_idx", w(done_idx[0]), w(171));
    check("t5b_rx_idx1", w(rx_idx[1]), w(173));
    check("t5b_no_load", w(n_ld), w(0));
    check("t5b_en_cycles", w(n_en), w(340));

    // 6: loopback through a model chip SR; second pass reads back the first word
    do_reset();
    mon_sel = 0;
    chip = '0;
    w_rand = DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    exp_q.push_back(W_K1);
    launch(W_K1);
    watch(180, 1'b0, -1, -1, -1);
    launch(w_rand);
    watch(180, 1'b0, -1, -1, -1);
    e = exp_q.pop_front();
    check("t6_capture", cap, e);
    check("t6_chip_holds_new", chip, w_rand);
    check("t6_valid", w(n_done), w(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
